alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver_if.sv | 41 ++++
 rtl/alu_driver.sv | 129 ++++++++++++
 tb/tb_alu_driver.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_driver_if.sv
// Handshake and ALU-facing bus for alu_driver; the in_acc request bit exists only
// when ALU_DRIVER_ACC_EN is defined.
interface alu_driver_if #(
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_oc;
   logic [3:0]       in_a;
   logic [3:0]       in_b;
`ifdef ALU_DRIVER_ACC_EN
   logic             in_acc;
`endif
   logic [2:0]       alu_oc;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_f;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       res;
   logic             busy;
   logic [CNT_W-1:0] op_cnt;

   // Block side of the bus
   modport slave (
`ifdef ALU_DRIVER_ACC_EN
      input  in_acc,
`endif
      input  in_valid, in_oc, in_a, in_b, alu_f, out_ready,
      output in_ready, alu_oc, alu_a, alu_b, out_valid, res, busy, op_cnt
   );

   // Requester / ALU / consumer side of the bus
   modport master (
`ifdef ALU_DRIVER_ACC_EN
      output in_acc,
`endif
      output in_valid, in_oc, in_a, in_b, alu_f, out_ready,
      input  in_ready, alu_oc, alu_a, alu_b, out_valid, res, busy, op_cnt
   );
endinterface

// File: rtl/alu_driver.sv
// Drives a combinational ALU with registered operands, captures its result and
// hands it downstream. Optional accumulator chaining via macro ALU_DRIVER_ACC_EN.
module alu_driver #(
   parameter int unsigned CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   alu_driver_if.slave  bus
);

   localparam int unsigned OC_W  = 3;
   localparam int unsigned DAT_W = 4;

   typedef struct packed {
      logic [OC_W-1:0]  oc;
      logic [DAT_W-1:0] a;
      logic [DAT_W-1:0] b;
   } req_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e             state_q, state_d;
   req_t               req_q, req_d;
   logic [DAT_W-1:0]   res_q, res_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;

   logic               in_ready_c;
   logic               accept_c;
   logic               consume_c;
   logic               load_res_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) state_d = S_EXEC;
         S_EXEC: state_d = S_HOLD;
         S_HOLD: begin
            if (bus.out_ready) state_d = bus.in_valid ? S_EXEC : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM-decoded controls; a HOLD slot reopens to requests only when the result drains
   always_comb begin
      in_ready_c = 1'b0;
      load_res_c = 1'b0;
      case (state_q)
         S_IDLE: in_ready_c = 1'b1;
         S_EXEC: load_res_c = 1'b1;
         S_HOLD: in_ready_c = bus.out_ready;
         default: in_ready_c = 1'b0;
      endcase
      accept_c  = bus.in_valid & in_ready_c;
      consume_c = out_valid_q & bus.out_ready;
   end

   // Datapath next values
   always_comb begin
      req_d       = req_q;
      res_d       = res_q;
      out_valid_d = out_valid_q;
      op_cnt_d    = op_cnt_q;
      busy_d      = (state_d != S_IDLE);

      if (accept_c) begin
         req_d.oc = bus.in_oc;
         req_d.b  = bus.in_b;
`ifdef ALU_DRIVER_ACC_EN
         req_d.a  = bus.in_acc ? res_q : bus.in_a;
`else
         req_d.a  = bus.in_a;
`endif
      end

      if (consume_c) begin
         out_valid_d = 1'b0;
         op_cnt_d    = op_cnt_q + CNT_W'(1);
      end

      if (load_res_c) begin
         res_d       = bus.alu_f;
         out_valid_d = 1'b1;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q       <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         op_cnt_q    <= '0;
      end else begin
         req_q       <= req_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.alu_oc    = req_q.oc;
   assign bus.alu_a     = req_q.a;
   assign bus.alu_b     = req_q.b;
   assign bus.res       = res_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: an 8-bit-counter and a 2-bit-counter instance
// share stimulus; the ALU is modelled as f = a + b mod 16.
module tb_alu_driver;

   logic clk;
   logic rst;

   int unsigned n_chk;
   int unsigned n_bad;

   alu_driver_if #(.CNT_W(8)) if8 ();
   alu_driver_if #(.CNT_W(2)) if2 ();

   alu_driver #(.CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
   alu_driver #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   assign if8.alu_f     = if8.alu_a + if8.alu_b;
   assign if2.alu_f     = if2.alu_a + if2.alu_b;
   assign if2.in_valid  = if8.in_valid;
   assign if2.in_oc     = if8.in_oc;
   assign if2.in_a      = if8.in_a;
   assign if2.in_b      = if8.in_b;
   assign if2.out_ready = if8.out_ready;
`ifdef ALU_DRIVER_ACC_EN
   assign if2.in_acc    = if8.in_acc;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] a_v [4];
   logic [3:0] b_v [4];
   logic [3:0] r_v [4];
   logic [3:0] acc_exp_a;
   logic [3:0] acc_exp_res;
   int unsigned cnt;

   initial begin
      n_chk = 0;
      n_bad = 0;
      a_v = '{4'd1, 4'd3, 4'd5, 4'd7};
      b_v = '{4'd2, 4'd4, 4'd6, 4'd7};
      r_v = '{4'd3, 4'd7, 4'd11, 4'd14};
`ifdef ALU_DRIVER_ACC_EN
      acc_exp_a   = 4'd6;
      acc_exp_res = 4'd8;
      if8.in_acc  = 1'b0;
`else
      acc_exp_a   = 4'd15;
      acc_exp_res = 4'd1;
`endif

      rst           = 1'b1;
      if8.in_valid  = 1'b0;
      if8.in_oc     = 3'd0;
      if8.in_a      = 4'd0;
      if8.in_b      = 4'd0;
      if8.out_ready = 1'b0;

      // reset state before any edge
      #3;
      check_eq("rst_res",       32'(if8.res), 32'd0);
      check_eq("rst_out_valid", 32'(if8.out_valid), 32'd0);
      check_eq("rst_busy",      32'(if8.busy), 32'd0);
      check_eq("rst_op_cnt",    32'(if8.op_cnt), 32'd0);
      check_eq("rst_alu_a",     32'(if8.alu_a), 32'd0);
      check_eq("rst_in_ready",  32'(if8.in_ready), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_eq("idle_no_accept", 32'(if8.busy), 32'd0);

      // single operation
      if8.in_valid  = 1'b1;
      if8.in_oc     = 3'b000;
      if8.in_a      = 4'b0011;
      if8.in_b      = 4'b0101;
      if8.out_ready = 1'b1;
      tick();
      check_eq("single_busy",      32'(if8.busy), 32'd1);
      check_eq("single_exec_rdy",  32'(if8.in_ready), 32'd0);
      check_eq("single_alu_a",     32'(if8.alu_a), 32'd3);
      check_eq("single_alu_b",     32'(if8.alu_b), 32'd5);
      check_eq("single_exec_ov",   32'(if8.out_valid), 32'd0);
      if8.in_valid = 1'b0;
      tick();
      check_eq("single_ov",        32'(if8.out_valid), 32'd1);
      check_eq("single_res",       32'(if8.res), 32'd8);
      check_eq("single_cnt_pre",   32'(if8.op_cnt), 32'd0);
      tick();
      check_eq("single_ov_clr",    32'(if8.out_valid), 32'd0);
      check_eq("single_cnt",       32'(if8.op_cnt), 32'd1);
      check_eq("single_idle",      32'(if8.busy), 32'd0);
      check_eq("wrap_cnt_1",       32'(if2.op_cnt), 32'd1);

      // backpressure
      if8.out_ready = 1'b0;
      if8.in_valid  = 1'b1;
      if8.in_a      = 4'b1111;
      if8.in_b      = 4'b0001;
      tick();
      if8.in_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_res",      32'(if8.res), 32'd0);
         check_eq("bp_ov",       32'(if8.out_valid), 32'd1);
         check_eq("bp_in_ready", 32'(if8.in_ready), 32'd0);
         check_eq("bp_cnt",      32'(if8.op_cnt), 32'd1);
         tick();
      end
      if8.out_ready = 1'b1;
      #1;
      check_eq("bp_release_rdy", 32'(if8.in_ready), 32'd1);
      tick();
      check_eq("bp_cnt_inc",  32'(if8.op_cnt), 32'd2);
      check_eq("bp_ov_clr",   32'(if8.out_valid), 32'd0);
      check_eq("wrap_cnt_2",  32'(if2.op_cnt), 32'd2);

      // back-to-back, in_valid held high; junk operands during EXEC must be ignored
      cnt = 2;
      if8.in_valid = 1'b1;
      if8.in_a     = a_v[0];
      if8.in_b     = b_v[0];
      tick();
      for (int k = 0; k < 4; k++) begin
         check_eq("b2b_exec_rdy", 32'(if8.in_ready), 32'd0);
         if8.in_a = 4'd9;
         if8.in_b = 4'd9;
         tick();
         check_eq("b2b_ov",    32'(if8.out_valid), 32'd1);
         check_eq("b2b_res",   32'(if8.res), 32'(r_v[k]));
         check_eq("b2b_alu_a", 32'(if8.alu_a), 32'(a_v[k]));
         if (k < 3) begin
            if8.in_a = a_v[k+1];
            if8.in_b = b_v[k+1];
         end else begin
            if8.in_valid = 1'b0;
         end
         tick();
         cnt++;
         check_eq("b2b_cnt",  32'(if8.op_cnt), 32'(cnt));
         check_eq("wrap_cnt", 32'(if2.op_cnt), 32'(cnt % 4));
         if (k < 3) begin
            check_eq("b2b_reaccept", 32'(if8.busy), 32'd1);
            check_eq("b2b_next_a",   32'(if8.alu_a), 32'(a_v[k+1]));
         end else begin
            check_eq("b2b_done_idle", 32'(if8.busy), 32'd0);
         end
      end

      // accumulator chaining (or plain load in the default build)
      if8.in_valid = 1'b1;
      if8.in_a     = 4'd2;
      if8.in_b     = 4'd4;
      tick();
      if8.in_valid = 1'b0;
      tick();
      check_eq("acc_seed_res", 32'(if8.res), 32'd6);
      tick();
      if8.in_valid = 1'b1;
      if8.in_a     = 4'b1111;
      if8.in_b     = 4'b0010;
`ifdef ALU_DRIVER_ACC_EN
      if8.in_acc   = 1'b1;
`endif
      tick();
      check_eq("acc_alu_a", 32'(if8.alu_a), 32'(acc_exp_a));
      if8.in_valid = 1'b0;
`ifdef ALU_DRIVER_ACC_EN
      if8.in_acc   = 1'b0;
`endif
      tick();
      check_eq("acc_res", 32'(if8.res), 32'(acc_exp_res));
      tick();
      check_eq("acc_cnt", 32'(if8.op_cnt), 32'd8);

      // asynchronous reset in HOLD
      if8.out_ready = 1'b0;
      if8.in_valid  = 1'b1;
      if8.in_a      = 4'b0011;
      if8.in_b      = 4'b0101;
      tick();
      if8.in_valid = 1'b0;
      tick();
      check_eq("hold_res_pre", 32'(if8.res), 32'd8);
      check_eq("hold_ov_pre",  32'(if8.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_res",    32'(if8.res), 32'd0);
      check_eq("arst_ov",     32'(if8.out_valid), 32'd0);
      check_eq("arst_cnt",    32'(if8.op_cnt), 32'd0);
      check_eq("arst_busy",   32'(if8.busy), 32'd0);
      check_eq("arst_alu_a",  32'(if8.alu_a), 32'd0);
      check_eq("arst_cnt2",   32'(if2.op_cnt), 32'd0);
      tick();
      rst = 1'b0;
      if8.out_ready = 1'b1;
      tick();
      check_eq("post_rst_idle", 32'(if8.busy), 32'd0);
      check_eq("post_rst_cnt",  32'(if8.op_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
